// File: rtl/reg_wb_stage.sv
// ---------------------------------------------------------------------------
// reg_wb_stage
//
// Register write-back stage for the NanoMIPS datapath. It picks the
// register-file write data from NSRC flattened sources and registers the
// data, address and write enable. A write sourced from memory (slot MEM_IDX)
// that arrives before the memory data is valid parks the stage in WAIT_MEM.
// While parked, in_ready is low so the front end stalls. The wait is bounded
// by TIMEOUT cycles, after which err pulses and the write is dropped.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   reset     - synchronous active-high reset
//   in_valid  - write request present
//   in_ready  - stage can accept a request this cycle (IDLE only)
//   in_sel    - source select (0 or out-of-range selects all-zero data)
//   in_waddr  - destination register address
//   src_data  - flattened sources, slot k at [k*WIDTH +: WIDTH]
//   mem_rdy   - memory data on slot MEM_IDX is valid this cycle
//   wb_en     - register-file write enable, one-cycle pulse
//   wb_addr   - register-file write address
//   wb_data   - register-file write data
//   err       - one-cycle pulse when a memory wait times out
// ---------------------------------------------------------------------------
module reg_wb_stage #(
    parameter int WIDTH            = 8,
    parameter int NSRC             = 5,
    parameter int SELW             = 3,
    parameter int ADDRW            = 4,
    parameter int MEM_IDX          = 2,
    parameter int TIMEOUT          = 15,
    parameter int ZERO_REG_PROTECT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       in_sel,
    input  logic [ADDRW-1:0]      in_waddr,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic                  mem_rdy,
    output logic                  wb_en,
    output logic [ADDRW-1:0]      wb_addr,
    output logic [WIDTH-1:0]      wb_data,
    output logic                  err
);

    localparam int CNTW = $clog2(TIMEOUT + 1);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_MEM = 1'b1;

    logic [0:0]       state;
    logic [CNTW-1:0]  count;
    logic [ADDRW-1:0] pend_addr;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] mem_data;
    logic             sel_is_mem;
    logic             req_zero;
    logic             pend_zero;

    // Source decode: slot 0 is never read, so in_sel==0 and any select past
    // the last slot both fall through to the all-zero default.
    always_comb begin
        sel_data = '0;
        for (int k = 1; k < NSRC; k++) begin
            if (in_sel == SELW'(k)) begin
                sel_data = src_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // The memory slot is tapped directly so a parked write can complete from
    // it regardless of what in_sel is doing while the stage is stalled.
    // Zero-register suppression is evaluated separately for the incoming
    // address and for the address captured when the wait started.
    always_comb begin
        mem_data   = src_data[MEM_IDX*WIDTH +: WIDTH];
        sel_is_mem = (in_sel == SELW'(MEM_IDX));
        req_zero   = (ZERO_REG_PROTECT != 0) && (in_waddr == '0);
        pend_zero  = (ZERO_REG_PROTECT != 0) && (pend_addr == '0);
    end

    // The handshake depends on state alone, so the front end never sees a
    // combinational path from mem_rdy or in_valid back to in_ready.
    always_comb begin
        in_ready = (state == IDLE);
    end

    // Main sequencer. wb_en and err default low each cycle so they can only
    // ever be single-cycle pulses; wb_addr/wb_data hold between writes.
    // In WAIT_MEM, mem_rdy is tested before the timeout compare so data
    // arriving on the final wait cycle still gets written.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            pend_addr <= '0;
            wb_en     <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            err       <= 1'b0;
        end else begin
            wb_en <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (sel_is_mem && !mem_rdy) begin
                            pend_addr <= in_waddr;
                            count     <= '0;
                            state     <= WAIT_MEM;
                        end else begin
                            wb_data <= sel_data;
                            wb_addr <= in_waddr;
                            wb_en   <= !req_zero;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem_rdy) begin
                        wb_data <= mem_data;
                        wb_addr <= pend_addr;
                        wb_en   <= !pend_zero;
                        count   <= '0;
                        state   <= IDLE;
                    end else if (count == CNTW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        count <= '0;
                        state <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_reg_wb_stage
//
// Directed bench for reg_wb_stage with hand-computed expectations. Two
// instances share all inputs: dut has zero-register protection on, dut0 has
// it off, so the protect case can be checked both ways in one pass.
// Inputs change 1 ns after the rising edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_reg_wb_stage;

    localparam int WIDTH = 8;
    localparam int NSRC  = 5;
    localparam int SELW  = 3;
    localparam int ADDRW = 4;

    logic                  clk;
    logic                  reset;
    logic                  in_valid;
    logic [SELW-1:0]       in_sel;
    logic [ADDRW-1:0]      in_waddr;
    logic [NSRC*WIDTH-1:0] src_data;
    logic                  mem_rdy;

    logic                  in_ready,  in_ready0;
    logic                  wb_en,     wb_en0;
    logic [ADDRW-1:0]      wb_addr,   wb_addr0;
    logic [WIDTH-1:0]      wb_data,   wb_data0;
    logic                  err,       err0;

    int errors = 0;
    int checks = 0;

    reg_wb_stage #(.ZERO_REG_PROTECT(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_waddr(in_waddr), .src_data(src_data),
        .mem_rdy(mem_rdy), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .err(err)
    );

    reg_wb_stage #(.ZERO_REG_PROTECT(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_sel(in_sel), .in_waddr(in_waddr), .src_data(src_data),
        .mem_rdy(mem_rdy), .wb_en(wb_en0), .wb_addr(wb_addr0),
        .wb_data(wb_data0), .err(err0)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a wedged run still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [SELW-1:0] s,
                                 input logic [ADDRW-1:0] a, input logic m);
        in_valid = v;
        in_sel   = s;
        in_waddr = a;
        mem_rdy  = m;
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sweepExp [8];
    int lowCycles;
    int errPulses;
    int writePulses;

    initial begin
        sweepExp = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00};
        // Slot 0 holds junk to show it is never selected.
        src_data = {8'h44, 8'h33, 8'h22, 8'h11, 8'hEE};
        applyStimulus(1'b0, '0, '0, 1'b0);
        reset = 1'b1;
        stepClk();
        stepClk();
        reset = 1'b0;
        stepClk();

        checkOutput("rst_wb_en",    32'(wb_en),    32'h0);
        checkOutput("rst_wb_addr",  32'(wb_addr),  32'h0);
        checkOutput("rst_wb_data",  32'(wb_data),  32'h0);
        checkOutput("rst_err",      32'(err),      32'h0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'h1);

        // Back-to-back select sweep, one write per cycle.
        for (int s = 0; s < 8; s++) begin
            applyStimulus(1'b1, SELW'(s), 4'd5, 1'b1);
            stepClk();
            checkOutput($sformatf("sweep%0d_en", s),    32'(wb_en),    32'h1);
            checkOutput($sformatf("sweep%0d_data", s),  32'(wb_data),  32'(sweepExp[s]));
            checkOutput($sformatf("sweep%0d_addr", s),  32'(wb_addr),  32'h5);
            checkOutput($sformatf("sweep%0d_ready", s), 32'(in_ready), 32'h1);
        end
        applyStimulus(1'b0, '0, '0, 1'b1);
        stepClk();
        checkOutput("idle_en",        32'(wb_en),   32'h0);
        checkOutput("idle_hold_data", 32'(wb_data), 32'h00);
        checkOutput("idle_hold_addr", 32'(wb_addr), 32'h5);

        // Memory stall: data becomes valid on the third stalled cycle.
        src_data[2*WIDTH +: WIDTH] = 8'hA5;
        applyStimulus(1'b1, 3'd2, 4'd7, 1'b0);
        stepClk();
        applyStimulus(1'b0, 3'd1, 4'd1, 1'b0);
        lowCycles   = 0;
        writePulses = 0;
        while (!in_ready && lowCycles < 40) begin
            lowCycles++;
            if (wb_en) writePulses++;
            if (lowCycles == 3) mem_rdy = 1'b1;
            stepClk();
        end
        checkOutput("stall_low_cycles", 32'(lowCycles),   32'd3);
        checkOutput("stall_early_write", 32'(writePulses), 32'd0);
        checkOutput("stall_en",   32'(wb_en),   32'h1);
        checkOutput("stall_addr", 32'(wb_addr), 32'h7);
        checkOutput("stall_data", 32'(wb_data), 32'hA5);
        checkOutput("stall_err",  32'(err),     32'h0);
        mem_rdy = 1'b0;
        stepClk();

        // Timeout: memory never answers.
        applyStimulus(1'b1, 3'd2, 4'd9, 1'b0);
        stepClk();
        applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
        lowCycles   = 0;
        errPulses   = 0;
        writePulses = 0;
        while (!in_ready && lowCycles < 40) begin
            lowCycles++;
            if (err) errPulses++;
            if (wb_en) writePulses++;
            stepClk();
        end
        if (err) errPulses++;
        if (wb_en) writePulses++;
        checkOutput("tmo_low_cycles", 32'(lowCycles),   32'd15);
        checkOutput("tmo_err_pulses", 32'(errPulses),   32'd1);
        checkOutput("tmo_no_write",   32'(writePulses), 32'd0);
        checkOutput("tmo_err_now",    32'(err),         32'h1);
        checkOutput("tmo_addr_hold",  32'(wb_addr),     32'h7);
        stepClk();
        checkOutput("tmo_err_single", 32'(err),      32'h0);
        checkOutput("tmo_ready",      32'(in_ready), 32'h1);

        // Zero-register protect, both parameter settings.
        applyStimulus(1'b1, 3'd1, 4'd0, 1'b0);
        stepClk();
        applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
        checkOutput("zp_en",        32'(wb_en),    32'h0);
        checkOutput("zp_addr",      32'(wb_addr),  32'h0);
        checkOutput("zp_data",      32'(wb_data),  32'h11);
        checkOutput("zp_ready",     32'(in_ready), 32'h1);
        checkOutput("zp_err",       32'(err),      32'h0);
        checkOutput("zp_off_en",    32'(wb_en0),   32'h1);
        checkOutput("zp_off_data",  32'(wb_data0), 32'h11);

        // A normal write so the mid-wait reset has nonzero values to clear.
        applyStimulus(1'b1, 3'd3, 4'd6, 1'b0);
        stepClk();
        checkOutput("pre_rst_data", 32'(wb_data), 32'h33);
        checkOutput("pre_rst_addr", 32'(wb_addr), 32'h6);

        // Reset on wait cycle 4 abandons the pending write.
        applyStimulus(1'b1, 3'd2, 4'd3, 1'b0);
        stepClk();
        applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
        stepClk();
        stepClk();
        stepClk();
        checkOutput("mid_wait_ready", 32'(in_ready), 32'h0);
        reset = 1'b1;
        stepClk();
        reset   = 1'b0;
        mem_rdy = 1'b1;
        stepClk();
        checkOutput("mrst_en",    32'(wb_en),    32'h0);
        checkOutput("mrst_addr",  32'(wb_addr),  32'h0);
        checkOutput("mrst_data",  32'(wb_data),  32'h0);
        checkOutput("mrst_err",   32'(err),      32'h0);
        checkOutput("mrst_ready", 32'(in_ready), 32'h1);
        stepClk();
        checkOutput("mrst_en_late",  32'(wb_en), 32'h0);
        checkOutput("mrst_err_late", 32'(err),   32'h0);

        // mem_rdy arriving on the last wait cycle beats the timeout.
        src_data[2*WIDTH +: WIDTH] = 8'h5A;
        applyStimulus(1'b1, 3'd2, 4'd4, 1'b0);
        stepClk();
        applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
        for (int i = 0; i < 14; i++) stepClk();
        checkOutput("prio_still_wait", 32'(in_ready), 32'h0);
        mem_rdy = 1'b1;
        stepClk();
        mem_rdy = 1'b0;
        checkOutput("prio_en",    32'(wb_en),    32'h1);
        checkOutput("prio_err",   32'(err),      32'h0);
        checkOutput("prio_data",  32'(wb_data),  32'h5A);
        checkOutput("prio_addr",  32'(wb_addr),  32'h4);
        checkOutput("prio_ready", 32'(in_ready), 32'h1);
        stepClk();
        checkOutput("prio_no_late_err", 32'(err), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
